dmem_ctrl: RTL and testbench

- Data-memory responder at the far end of the execute stage's data-address/store-data interface.
- Accepts one load or store request per handshake and drives a synchronous block RAM with fixed read latency.
- Returns load data with a one-cycle valid pulse.
- Provides the n_stall enable that freezes the pipeline while a load is outstanding.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_cycle_cnt.sv | 21 ++
 rtl/dmem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'd0,
        SRC_ZERO = 2'd1,
        SRC_CNT  = 2'd2
    } rd_src_t;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [29:0] CNT_ADDR   = 30'h3FFF_FFFF;
    localparam int          RD_LAT_MAX = 3;

endpackage

// File: rtl/dmem_cycle_cnt.sv
// Free-running 32-bit cycle counter with a synchronous load port.
module dmem_cycle_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] count
);

    // Count every cycle; a load replaces the next value and wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'h0;
        end else if (load) begin
            count <= load_value;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder driving a fixed-latency synchronous BRAM.
// Optional cycle counter at CNT_ADDR enabled by DMEM_CYCLE_CNT_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [29:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              n_stall,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    generate
        if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("dmem_ctrl: RD_LAT out of range 1..3");
        end
    endgenerate

    state_t      state_r;
    state_t      state_s;
    rd_src_t     rd_src_r;
    logic [1:0]  lat_cnt_r;
    req_t        req_s;
    logic        in_range_s;
    logic        is_cnt_s;
    logic        accept_s;
    logic        rd_done_s;
    logic [31:0] cnt_snap;

    assign req_s      = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign in_range_s = (req_s.addr[29:ADDR_W] == {(30-ADDR_W){1'b0}});
    assign accept_s   = req_valid && (state_r == IDLE);
    assign rd_done_s  = (state_r == RD_WAIT) && (lat_cnt_r == 2'd0);
    assign req_ready  = (state_r == IDLE);
    assign n_stall    = (state_r == IDLE);

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cnt_value_s;
    logic        cnt_load_s;
    logic [31:0] cnt_snap_r;

    assign is_cnt_s   = (req_s.addr == CNT_ADDR);
    assign cnt_load_s = accept_s && req_s.we && is_cnt_s;

    dmem_cycle_cnt u_cycle_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load_s),
        .load_value (req_s.wdata),
        .count      (cnt_value_s)
    );

    // A load returns the value the counter holds in the cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_snap_r <= 32'h0;
        end else if (accept_s && !req_s.we && is_cnt_s) begin
            cnt_snap_r <= cnt_value_s + 32'd1;
        end else begin
            cnt_snap_r <= cnt_snap_r;
        end
    end

    assign cnt_snap = cnt_snap_r;
`else
    assign is_cnt_s = 1'b0;
    assign cnt_snap = 32'h0;
`endif

    // Next-state logic for the load wait sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !req_s.we) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_r == 2'd0) begin
                    state_s = IDLE;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // BRAM port follows the request combinationally while idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = 32'h0;
        if (state_r == IDLE) begin
            mem_en    = req_valid && in_range_s;
            mem_we    = req_valid && in_range_s && req_s.we;
            mem_addr  = req_s.addr[ADDR_W-1:0];
            mem_wdata = req_s.wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // State, latency counter, response and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            lat_cnt_r <= 2'd0;
            rd_src_r  <= SRC_MEM;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            addr_err  <= 1'b0;
        end else begin
            state_r   <= state_s;
            rsp_valid <= rd_done_s;

            if (accept_s && !req_s.we) begin
                lat_cnt_r <= 2'(RD_LAT - 1);
                if (in_range_s) begin
                    rd_src_r <= SRC_MEM;
                end else if (is_cnt_s) begin
                    rd_src_r <= SRC_CNT;
                end else begin
                    rd_src_r <= SRC_ZERO;
                end
            end else if ((state_r == RD_WAIT) && (lat_cnt_r != 2'd0)) begin
                lat_cnt_r <= lat_cnt_r - 2'd1;
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end

            if (rd_done_s) begin
                case (rd_src_r)
                    SRC_MEM: rsp_rdata <= mem_rdata;
                    SRC_CNT: rsp_rdata <= cnt_snap;
                    default: rsp_rdata <= 32'h0;
                endcase
            end else begin
                rsp_rdata <= rsp_rdata;
            end

            if (accept_s && !in_range_s && !is_cnt_s) begin
                addr_err <= 1'b1;
            end else begin
                addr_err <= addr_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a transaction-level reference model.
module tb_dmem_ctrl;
    localparam int ADDR_W = 15;
    localparam int RD_LAT = 2;
    localparam logic [29:0] CNT_A = 30'h3FFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [29:0] req_addr = 30'h0;
    logic [31:0] req_wdata = 32'h0;
    logic req_ready, rsp_valid, n_stall, addr_err, mem_en, mem_we;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    dmem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .n_stall(n_stall),
        .addr_err(addr_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // BRAM with RD_LAT-cycle read latency
    logic [31:0] bram [0:(1<<ADDR_W)-1];
    logic [31:0] rd_pipe [0:RD_LAT-1];
    assign mem_rdata = rd_pipe[RD_LAT-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) bram[i] = 32'h0;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? bram[mem_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference model: transaction rules expressed in cycle numbers
    int checks = 0, errors = 0;
    longint cyc = 0;
    longint ready_at = 0, rsp_at = -1, err_at = 0;
    bit err_on = 1'b0;
    logic [31:0] pend = 32'h0, m_rdata = 32'h0;
    logic [31:0] model_mem [int];
    logic [31:0] cnt_base = 32'h0;
    longint cnt_cycle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [29:0] a);
        return (a >> ADDR_W) == 30'h0;
    endfunction

    function automatic logic [31:0] mem_val(input logic [29:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return 32'h0;
    endfunction

    function automatic bit is_cnt(input logic [29:0] a);
`ifdef DMEM_CYCLE_CNT_EN
        return a == CNT_A;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step(input logic v, input logic we, input logic [29:0] a, input logic [31:0] d);
        bit rdy, en;
        req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        #3;
        rdy = (cyc >= ready_at);
        if (cyc == rsp_at) m_rdata = pend;
        en = rdy && v && in_rng(a);
        chk("req_ready", {31'h0, req_ready}, {31'h0, rdy});
        chk("n_stall", {31'h0, n_stall}, {31'h0, rdy});
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, (cyc == rsp_at)});
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("addr_err", {31'h0, addr_err}, {31'h0, (err_on && cyc >= err_at)});
        chk("mem_en", {31'h0, mem_en}, {31'h0, en});
        chk("mem_we", {31'h0, mem_we}, {31'h0, (en && we)});
        chk("mem_addr", {17'h0, mem_addr}, rdy ? {17'h0, a[ADDR_W-1:0]} : 32'h0);
        chk("mem_wdata", mem_wdata, rdy ? d : 32'h0);
        if (rdy && v) begin
            if (!in_rng(a) && !is_cnt(a) && !err_on) begin
                err_on = 1'b1; err_at = cyc + 1;
            end
            if (we) begin
                if (in_rng(a)) model_mem[int'(a)] = d;
                else if (is_cnt(a)) begin cnt_base = d; cnt_cycle = cyc + 1; end
            end else begin
                ready_at = cyc + RD_LAT + 1;
                rsp_at   = cyc + RD_LAT + 1;
                if (in_rng(a)) pend = mem_val(a);
                else if (is_cnt(a)) pend = cnt_base + 32'(cyc + 1 - cnt_cycle);
                else pend = 32'h0;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 30'h0, 32'h0);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_n_stall", {31'h0, n_stall}, 32'h1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc += 2;
        ready_at = cyc; rsp_at = -1; err_on = 1'b0; m_rdata = 32'h0;
        cnt_base = 32'h0; cnt_cycle = cyc;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        idle(2);

        // Store then load, load held while busy is accepted on the rsp_valid cycle
        step(1'b1, 1'b1, 30'd5, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 30'd5, 32'h0);
        chk("lit_busy", {31'h0, req_ready}, 32'h0);
        step(1'b1, 1'b0, 30'd0, 32'h0);
        step(1'b1, 1'b0, 30'd0, 32'h0);
        chk("lit_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("lit_rsp_data", rsp_rdata, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 30'd0, 32'h0);
        idle(3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 30'(i), 32'(i + 1));
        step(1'b1, 1'b0, 30'd2, 32'h0);
        idle(2);
        chk("lit_b2b_data", rsp_rdata, 32'h3);
        idle(1);

        // Out-of-range load after an in-range one
        do_reset();
        step(1'b1, 1'b0, 30'd3, 32'h0);
        idle(2);
        step(1'b1, 1'b0, 30'h0000_8000, 32'h0);
        chk("lit_oor_err", {31'h0, addr_err}, 32'h1);
        idle(2);
        chk("lit_oor_valid", {31'h0, rsp_valid}, 32'h1);
        chk("lit_oor_data", rsp_rdata, 32'h0);
        step(1'b1, 1'b0, 30'd1, 32'h0);
        idle(3);
        chk("lit_err_sticky", {31'h0, addr_err}, 32'h1);
        chk("lit_after_oor", rsp_rdata, 32'h2);
        step(1'b1, 1'b1, 30'h0001_0000, 32'h1234_5678);
        idle(2);

        // Reset during an outstanding load
        do_reset();
        step(1'b1, 1'b0, 30'd4, 32'h0);
        do_reset();
        chk("lit_rst_ready", {31'h0, req_ready}, 32'h1);
        idle(5);

        // Cycle counter address
        do_reset();
        step(1'b1, 1'b1, CNT_A, 32'hFFFF_FFFE);
        idle(1);
        step(1'b1, 1'b0, CNT_A, 32'h0);
        idle(2);
        chk("lit_cnt_valid", {31'h0, rsp_valid}, 32'h1);
        chk("lit_cnt_data", rsp_rdata, 32'h0);
`ifdef DMEM_CYCLE_CNT_EN
        chk("lit_cnt_err", {31'h0, addr_err}, 32'h0);
`else
        chk("lit_cnt_err", {31'h0, addr_err}, 32'h1);
`endif
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
